// File: rtl/md_defs.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encoding, operand widths and default latencies.
package md_defs;

    localparam int MD_OP_W = 3;
    localparam int CNT_W   = 8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Code 7 is deliberately left out; the unit treats it like MD_NONE.
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_comb.sv
// Combinational 32-bit divider, signed or unsigned. Signed results truncate
// toward zero and the remainder takes the dividend's sign.
module md_div_comb (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_isSigned,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_magQ;
    logic [31:0] w_magR;

    // Dividing magnitudes keeps 0x80000000 / -1 well defined: the magnitude
    // quotient is 0x80000000 and no negation is applied.
    assign w_negA = i_isSigned & i_a[31];
    assign w_negB = i_isSigned & i_b[31];
    assign w_magA = w_negA ? (32'd0 - i_a) : i_a;
    assign w_magB = w_negB ? (32'd0 - i_b) : i_b;

    assign w_magQ = (w_magB == 32'd0) ? 32'd0 : (w_magA / w_magB);
    assign w_magR = (w_magB == 32'd0) ? 32'd0 : (w_magA % w_magB);

    assign o_quot = (w_negA ^ w_negB) ? (32'd0 - w_magQ) : w_magQ;
    assign o_rem  = w_negA ? (32'd0 - w_magR) : w_magR;

endmodule

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes results at the
// start edge and releases them to HI/LO after a fixed busy window.
module e_muldiv
    import md_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               start,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_e        r_state;
    md_state_e        w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pHi;
    logic [31:0]      r_pLo;
    logic             r_pKeep;

    logic        w_isMul;
    logic        w_isDiv;
    logic        w_cntDone;
    logic [63:0] w_mulS;
    logic [63:0] w_mulU;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_isMul   = (op == MD_MULT) || (op == MD_MULTU);
    assign w_isDiv   = (op == MD_DIV)  || (op == MD_DIVU);
    assign busy      = (r_state == ST_BUSY);
    assign start     = (w_isMul || w_isDiv) && !busy;
    assign w_cntDone = (r_cnt == CNT_W'(1));
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Sign-extended operands multiplied at 64 bits give the two's-complement
    // signed product in the low 64 bits.
    assign w_mulS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_mulU = {32'd0, a} * {32'd0, b};

    md_div_comb u_div (
        .i_a        (a),
        .i_b        (b),
        .i_isSigned (op == MD_DIV),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (start)     w_nextState = ST_BUSY;
            ST_BUSY: if (w_cntDone) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // A divide by zero still runs its full window but leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_pHi   <= '0;
            r_pLo   <= '0;
            r_pKeep <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_cnt   <= w_isMul ? MULT_N : DIV_N;
                r_pKeep <= w_isDiv && (b == 32'd0);
                if (w_isMul) begin
                    {r_pHi, r_pLo} <= (op == MD_MULT) ? w_mulS : w_mulU;
                end else begin
                    r_pHi <= w_rem;
                    r_pLo <= w_quot;
                end
            end else if (op == MD_MTHI) begin
                r_hi <= a;
            end else if (op == MD_MTLO) begin
                r_lo <= a;
            end
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_cntDone && !r_pKeep) begin
                r_hi <= r_pHi;
                r_lo <= r_pLo;
            end
        end
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Bench for e_muldiv: directed vector table, randomized ops against a
// plain-arithmetic reference model, and a reset-abort sequence.
module tb_e_muldiv;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCyc;
        bit          interfere;
        string       name;
    } vec_t;

    vec_t vecs[$];

    e_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .a     (a),
        .b     (b),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && busy && (op == MD_MTHI || op == MD_MTLO)) begin
            bad++;
            $display("[TB] FAIL mt_while_busy op=%0d busy=%0b required no MTHI/MTLO", op, busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Reference: 64-bit arithmetic straight from the instruction semantics.
    function automatic void refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     inout logic [31:0] h, inout logic [31:0] l, output int cyc);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint p;
        longint q;
        longint r;
        longint unsigned pu;
        cyc = 0;
        case (o)
            3'd1: begin p = sx * sy; h = p[63:32]; l = p[31:0]; cyc = 5; end
            3'd2: begin pu = {32'd0, x} * {32'd0, y}; h = pu[63:32]; l = pu[31:0]; cyc = 5; end
            3'd3: begin
                cyc = 10;
                if (y != 0) begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
            end
            3'd4: begin
                cyc = 10;
                if (y != 0) begin l = x / y; h = x % y; end
            end
            3'd5: h = x;
            3'd6: l = x;
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc,
                                 input bit interfere, input string name);
        int n = 0;
        op = o; a = x; b = y;
        #1;
        checkOutput({name, " start"}, {31'd0, start}, {31'd0, (eCyc != 0)});
        tick();
        op = 3'd0;
        if (eCyc == 0) begin
            checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
        end else begin
            while (busy && n < 50) begin
                checkOutput({name, " hiHeld"}, hi, mHi);
                checkOutput({name, " loHeld"}, lo, mLo);
                if (interfere && n == 0) begin
                    op = MD_DIV; a = $urandom; b = 32'd3;
                    #1;
                    checkOutput({name, " startWhileBusy"}, {31'd0, start}, 32'd0);
                end
                n++;
                tick();
                op = 3'd0;
            end
            checkOutput({name, " busyCycles"}, n, eCyc);
        end
        checkOutput({name, " hi"}, hi, eHi);
        checkOutput({name, " lo"}, lo, eLo);
        mHi = eHi;
        mLo = eLo;
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [31:0] eH;
        logic [31:0] eL;
        int          eC;

        vecs.push_back('{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5,  1'b0, "mult_neg"});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5,  1'b1, "multu"});
        vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, "div_neg"});
        vecs.push_back('{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10, 1'b0, "divu"});
        vecs.push_back('{3'd5, 32'h11,       32'd0,        32'h00000011, 32'h00000003, 0,  1'b0, "mthi_pre"});
        vecs.push_back('{3'd6, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 0,  1'b0, "mtlo_pre"});
        vecs.push_back('{3'd4, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10, 1'b0, "divu_zero"});
        vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0, "div_ovf"});
        vecs.push_back('{3'd5, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h80000000, 0,  1'b0, "mthi"});
        vecs.push_back('{3'd6, 32'h12345678, 32'd0,        32'hDEADBEEF, 32'h12345678, 0,  1'b0, "mtlo"});
        vecs.push_back('{3'd7, 32'd99,       32'd1,        32'hDEADBEEF, 32'h12345678, 0,  1'b0, "op7"});
        vecs.push_back('{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5,  1'b0, "mult_max"});
        vecs.push_back('{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0, "div_negb"});

        reset = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo,
                          vecs[i].expCyc, vecs[i].interfere, vecs[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = $urandom;
            case ($urandom_range(0, 5))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 15));
                2:       rB = 32'd0 - 32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            eH = mHi;
            eL = mLo;
            refModel(rOp, rA, rB, eH, eL, eC);
            applyStimulus(rOp, rA, rB, eH, eL, eC, 1'b0, $sformatf("rand%0d", i));
        end

        applyStimulus(MD_MTHI, 32'h0000AAAA, 32'd0, 32'h0000AAAA, mLo, 0, 1'b0, "mthi_prerst");
        op = MD_MULT; a = 32'd3; b = 32'd4;
        tick();
        op = 3'd0;
        tick();
        tick();
        checkOutput("abort busyBefore", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        repeat (6) tick();
        checkOutput("abort lateHi", hi, 32'd0);
        checkOutput("abort lateLo", lo, 32'd0);
        checkOutput("abort lateBusy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_muldiv.md
Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit of the 5-stage pipelined MIPS core.
- Sits directly downstream of the D/E pipeline register and consumes the E-stage operands (RS_E, RT_E) plus a decoded md op.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy window.
- The hazard unit uses start/busy to stall md-class instructions held in D.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state.
- op  in  3  decoded md op of the instruction in E (package encoding).
- a  in  32  operand A, forwarded RS_E value.
- b  in  32  operand B, forwarded RT_E value.
- start  out  1  combinational; op is MULT/MULTU/DIV/DIVU and busy==0.
- busy  out  1  registered; an operation is in flight.
- hi  out  32  HI register, registered.
- lo  out  32  LO register, registered.

Behaviour:
Clock and reset:
- Clock clk; reset reset, synchronous, active-high.
- On a reset edge: hi=0, lo=0, busy=0, cnt=0, pending results=0. Reset mid-operation aborts it; HI/LO are not updated.

Op encoding:
- MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and above are treated as MD_NONE.

Start of an operation:
- At an edge with start=1, compute the result into pending regs p_hi/p_lo.
- Load cnt with MULT_CYCLES or DIV_CYCLES, and set busy=1.

Arithmetic:
- MULT: signed 32x32 to 64-bit product; {p_hi,p_lo} = product.
- MULTU: unsigned 32x32 to 64-bit product; {p_hi,p_lo} = product.
- DIV: p_lo = quotient truncated toward zero; p_hi = remainder with the sign of the dividend.
- DIVU: p_lo = a/b, p_hi = a%b (unsigned).
- Signed overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- b==0 on DIV or DIVU: the op still occupies DIV_CYCLES busy cycles; on completion HI/LO keep their prior values.

Counting and completion:
- While busy, each edge decrements cnt.
- At the edge where cnt goes 1→0: hi<=p_hi, lo<=p_lo, busy<=0.
- busy is therefore high for exactly N edges after the start edge. A MFHI/MFLO issued afterwards reads the new value.

Ops arriving while busy=1:
- A MULT/MULTU/DIV/DIVU op is ignored; start=0 and no restart.
- MTHI/MTLO are ignored. The hazard unit guarantees neither case occurs; the bench flags them as assertions.

MTHI/MTLO:
- With busy=0: MTHI writes hi<=a at the next edge; MTLO writes lo<=a. Single cycle, busy is unaffected.

Other rules:
- The op input is sampled every cycle with no hold. A stalled D stage feeds bubbles (op=0) into E.
- Completion edge and a new start on the same edge cannot coincide, because busy blocks start.
- The cycle immediately after completion may start a new op (back-to-back).
- Stall contract for the hazard unit: stall D when the D instruction is md-class (incl. MFHI/MFLO/MTHI/MTLO) and (start|busy)==1.

Decomposition:
- Package md_defs: the op codes above, MD_OP_W=3, and default latency constants.
- No sub-module required. Optionally factor signed/unsigned divide into md_div_comb (combinational) for reuse.
- Counter, busy and HI/LO state stay in e_muldiv.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → start=1 for one cycle, busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged during busy.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; a DIV presented during busy is ignored (start=0).
- DIV a=0xFFFFFFF9 (-7), b=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=5, b=0 with prior hi=0x11, lo=0x22 → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 on consecutive cycles → hi=0xDEADBEEF, lo=0x12345678 one edge after each; busy stays 0.
- MULT started, reset asserted at busy cycle 3 → next edge busy=0, hi=lo=0; no late write on the following cycles.
